// File: rtl/coherence_snoop_initiator_pkg.sv
// Shared types for the coherence snoop initiator: snoop type codes,
// response codes, FSM states and a saturating counter helper.
package coherence_pkg;

  localparam int SNOOP_TYPE_W = 3;

  typedef enum logic [SNOOP_TYPE_W-1:0] {
    SNP_READ_SHARED   = 3'd0,
    SNP_READ_UNIQUE   = 3'd1,
    SNP_CLEAN_INVALID = 3'd2,
    SNP_MAKE_INVALID  = 3'd3,
    SNP_CLEAN_SHARED  = 3'd4
  } snoop_type_e;

  localparam logic [2:0] SNP_RESP_OKAY   = 3'd0;
  localparam logic [2:0] SNP_RESP_SHARED = 3'd1;
  localparam logic [2:0] SNP_RESP_PASSDIRTY = 3'd2;
  localparam logic [2:0] SNP_RESP_UNIQUE = 3'd3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_COMPLETE
  } snoop_state_e;

  // Codes above CLEAN_SHARED are reserved and are never sent to the fabric
  function automatic logic type_is_legal(input logic [SNOOP_TYPE_W-1:0] t);
    return t <= SNP_CLEAN_SHARED;
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/coherence_snoop_initiator_rr_arbiter.sv
// Round-robin arbiter: searches upward from rr_ptr with wrap and moves the
// pointer past the winner whenever the grant is consumed.
module rr_arbiter #(
  parameter int N    = 4,
  parameter int ID_W = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            advance,
  output logic [N-1:0]    grant,
  output logic [ID_W-1:0] grant_id,
  output logic            grant_any
);

  logic [ID_W-1:0] rr_ptr;

  always_comb begin
    int idx;
    logic [ID_W-1:0] cand;
    grant     = '0;
    grant_id  = '0;
    grant_any = 1'b0;
    idx       = 0;
    cand      = '0;
    for (int i = 0; i < N; i++) begin
      idx = int'(rr_ptr) + i;
      if (idx >= N) idx = idx - N;
      cand = ID_W'(idx);
      if (!grant_any && req[cand]) begin
        grant_any   = 1'b1;
        grant_id    = cand;
        grant[cand] = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
    end else if (advance) begin
      rr_ptr <= (int'(grant_id) == N - 1) ? '0 : grant_id + ID_W'(1);
    end
  end

endmodule

// File: rtl/coherence_snoop_initiator.sv
// Snoop initiator: arbitrates agent requests, issues one snoop at a time,
// samples the aggregated response after a fixed latency and returns a completion.
module coherence_snoop_initiator
  import coherence_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int ADDR_WIDTH   = 64,
  parameter int RESP_LATENCY = 2,
  parameter int ID_W         = $clog2(NUM_REQ)
) (
  input  logic                               clk,
  input  logic                               rst_n,
  input  logic [NUM_REQ-1:0]                 req_valid,
  output logic [NUM_REQ-1:0]                 req_ready,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0]      req_addr,
  input  logic [NUM_REQ*SNOOP_TYPE_W-1:0]    req_type,
  output logic [NUM_REQ-1:0]                 cpl_valid,
  output logic                               cpl_hit,
  output logic                               cpl_dirty,
  output logic [2:0]                         cpl_resp,
  output logic                               cpl_err,
  output logic                               snoop_req,
  output logic [ADDR_WIDTH-1:0]              snoop_addr,
  output logic [SNOOP_TYPE_W-1:0]            snoop_type,
  input  logic                               snoop_hit,
  input  logic                               snoop_dirty,
  input  logic [2:0]                         snoop_resp,
  output logic                               busy,
  output logic [31:0]                        stat_issued,
  output logic [31:0]                        stat_hits,
  output logic [31:0]                        stat_dirty
);

  localparam int CNT_W = (RESP_LATENCY > 1) ? $clog2(RESP_LATENCY) : 1;

  snoop_state_e             state;
  logic [ID_W-1:0]          cur_id;
  logic [CNT_W-1:0]         wait_cnt;
  logic [NUM_REQ-1:0]       grant;
  logic [ID_W-1:0]          grant_id;
  logic                     grant_any;
  logic                     accept;
  logic [ADDR_WIDTH-1:0]    sel_addr;
  logic [SNOOP_TYPE_W-1:0]  sel_type;

  // The handshake completes in the same cycle the grant is shown; never during reset
  assign accept    = rst_n && (state == S_IDLE) && grant_any;
  assign req_ready = accept ? grant : '0;
  assign busy      = (state != S_IDLE);
  assign sel_addr  = req_addr[int'(grant_id)*ADDR_WIDTH +: ADDR_WIDTH];
  assign sel_type  = req_type[int'(grant_id)*SNOOP_TYPE_W +: SNOOP_TYPE_W];

  rr_arbiter #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_arb (
    .clk       (clk),
    .rst_n     (rst_n),
    .req       (req_valid),
    .advance   (accept),
    .grant     (grant),
    .grant_id  (grant_id),
    .grant_any (grant_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      cur_id      <= '0;
      wait_cnt    <= '0;
      snoop_req   <= 1'b0;
      snoop_addr  <= '0;
      snoop_type  <= '0;
      cpl_valid   <= '0;
      cpl_hit     <= 1'b0;
      cpl_dirty   <= 1'b0;
      cpl_resp    <= SNP_RESP_OKAY;
      cpl_err     <= 1'b0;
      stat_issued <= '0;
      stat_hits   <= '0;
      stat_dirty  <= '0;
    end else begin
      snoop_req <= 1'b0;
      cpl_valid <= '0;
      cpl_hit   <= 1'b0;
      cpl_dirty <= 1'b0;
      cpl_resp  <= SNP_RESP_OKAY;
      cpl_err   <= 1'b0;

      case (state)
        S_IDLE: begin
          if (accept) begin
            cur_id <= grant_id;
            if (type_is_legal(sel_type)) begin
              state       <= S_ISSUE;
              snoop_req   <= 1'b1;
              snoop_addr  <= sel_addr;
              snoop_type  <= sel_type;
              wait_cnt    <= CNT_W'(RESP_LATENCY - 1);
              stat_issued <= sat_inc(stat_issued);
            end else begin
              // Reserved type: report an error without touching the fabric
              state     <= S_COMPLETE;
              cpl_valid <= NUM_REQ'(1) << grant_id;
              cpl_err   <= 1'b1;
            end
          end
        end

        S_ISSUE: begin
          state <= S_WAIT;
        end

        S_WAIT: begin
          if (wait_cnt == '0) begin
            state     <= S_COMPLETE;
            cpl_valid <= NUM_REQ'(1) << cur_id;
            cpl_hit   <= snoop_hit;
            cpl_dirty <= snoop_dirty;
            cpl_resp  <= snoop_resp;
            if (snoop_hit)   stat_hits  <= sat_inc(stat_hits);
            if (snoop_dirty) stat_dirty <= sat_inc(stat_dirty);
          end else begin
            wait_cnt <= wait_cnt - CNT_W'(1);
          end
        end

        S_COMPLETE: begin
          state <= S_IDLE;
        end

        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_coherence_snoop_initiator.sv
// Directed self-checking bench for coherence_snoop_initiator with NUM_REQ=4,
// ADDR_WIDTH=64, RESP_LATENCY=2; every expected value is hand-derived.
module tb_coherence_snoop_initiator;

  logic         clk;
  logic         rst_n;
  logic [3:0]   req_valid;
  logic [3:0]   req_ready;
  logic [255:0] req_addr;
  logic [11:0]  req_type;
  logic [3:0]   cpl_valid;
  logic         cpl_hit;
  logic         cpl_dirty;
  logic [2:0]   cpl_resp;
  logic         cpl_err;
  logic         snoop_req;
  logic [63:0]  snoop_addr;
  logic [2:0]   snoop_type;
  logic         snoop_hit;
  logic         snoop_dirty;
  logic [2:0]   snoop_resp;
  logic         busy;
  logic [31:0]  stat_issued;
  logic [31:0]  stat_hits;
  logic [31:0]  stat_dirty;

  int compared = 0;
  int mismatched = 0;

  coherence_snoop_initiator #(
    .NUM_REQ      (4),
    .ADDR_WIDTH   (64),
    .RESP_LATENCY (2)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_addr    (req_addr),
    .req_type    (req_type),
    .cpl_valid   (cpl_valid),
    .cpl_hit     (cpl_hit),
    .cpl_dirty   (cpl_dirty),
    .cpl_resp    (cpl_resp),
    .cpl_err     (cpl_err),
    .snoop_req   (snoop_req),
    .snoop_addr  (snoop_addr),
    .snoop_type  (snoop_type),
    .snoop_hit   (snoop_hit),
    .snoop_dirty (snoop_dirty),
    .snoop_resp  (snoop_resp),
    .busy        (busy),
    .stat_issued (stat_issued),
    .stat_hits   (stat_hits),
    .stat_dirty  (stat_dirty)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input int agent, input logic [63:0] addr,
                               input logic [2:0] typ);
    req_valid[agent]         = 1'b1;
    req_addr[agent*64 +: 64] = addr;
    req_type[agent*3 +: 3]   = typ;
  endtask

  // Returns the first non-zero req_ready seen at a negedge within the budget
  task automatic waitAccept(output logic [3:0] g);
    logic seen;
    seen = 1'b0;
    g    = 4'b0000;
    for (int c = 0; c < 20 && !seen; c++) begin
      #1;
      if (req_ready != 4'b0000) begin
        seen = 1'b1;
        g    = req_ready;
      end else begin
        tick();
      end
    end
    if (!seen) checkOutput("accept_timeout", {63'd0, seen}, 64'd1);
  endtask

  initial begin
    logic [3:0] g;

    rst_n       = 1'b0;
    req_valid   = '0;
    req_addr    = '0;
    req_type    = '0;
    snoop_hit   = 1'b0;
    snoop_dirty = 1'b0;
    snoop_resp  = 3'd0;

    // Reset: a pending request must not be accepted while rst_n is low
    @(negedge clk);
    applyStimulus(0, 64'hAAAA, 3'd0);
    tick();
    tick();
    #1;
    checkOutput("rst_ready", {60'd0, req_ready}, 64'd0);
    checkOutput("rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("rst_snoop_req", {63'd0, snoop_req}, 64'd0);
    checkOutput("rst_cpl_valid", {60'd0, cpl_valid}, 64'd0);
    checkOutput("rst_snoop_addr", snoop_addr, 64'd0);
    checkOutput("rst_stat_issued", {32'd0, stat_issued}, 64'd0);
    req_valid = '0;
    @(negedge clk);
    rst_n = 1'b1;
    tick();

    // Fairness: all agents request continuously; order 0,1,2,3,0
    for (int a = 0; a < 4; a++) applyStimulus(a, 64'h100 * (a + 1), 3'd0);
    for (int i = 0; i < 5; i++) begin
      waitAccept(g);
      checkOutput($sformatf("fair_grant%0d", i), {60'd0, g}, 64'd1 << (i % 4));
      @(negedge clk);
    end
    req_valid = '0;
    tick();
    tick();
    tick();
    checkOutput("fair_cpl_valid", {60'd0, cpl_valid}, 64'b0001);
    checkOutput("fair_stat_issued", {32'd0, stat_issued}, 64'd5);
    checkOutput("fair_stat_hits", {32'd0, stat_hits}, 64'd0);
    tick();

    // Single request from agent 2 (rr_ptr is 1)
    applyStimulus(2, 64'h1000, 3'd1);
    #1;
    checkOutput("single_ready", {60'd0, req_ready}, 64'b0100);
    tick();
    req_valid = '0;
    checkOutput("single_snoop_req", {63'd0, snoop_req}, 64'd1);
    checkOutput("single_snoop_addr", snoop_addr, 64'h1000);
    checkOutput("single_snoop_type", {61'd0, snoop_type}, 64'd1);
    checkOutput("single_busy", {63'd0, busy}, 64'd1);
    checkOutput("single_stat_issued", {32'd0, stat_issued}, 64'd6);
    tick();
    checkOutput("single_req_one_cycle", {63'd0, snoop_req}, 64'd0);
    tick();
    snoop_hit   = 1'b1;
    snoop_dirty = 1'b1;
    snoop_resp  = 3'd3;
    checkOutput("single_no_early_cpl", {60'd0, cpl_valid}, 64'd0);
    checkOutput("single_addr_held", snoop_addr, 64'h1000);
    tick();
    snoop_hit   = 1'b0;
    snoop_dirty = 1'b0;
    snoop_resp  = 3'd0;
    checkOutput("single_cpl_valid", {60'd0, cpl_valid}, 64'b0100);
    checkOutput("single_cpl_hit", {63'd0, cpl_hit}, 64'd1);
    checkOutput("single_cpl_dirty", {63'd0, cpl_dirty}, 64'd1);
    checkOutput("single_cpl_resp", {61'd0, cpl_resp}, 64'd3);
    checkOutput("single_cpl_err", {63'd0, cpl_err}, 64'd0);
    checkOutput("single_stat_hits", {32'd0, stat_hits}, 64'd1);
    checkOutput("single_stat_dirty", {32'd0, stat_dirty}, 64'd1);
    tick();
    checkOutput("single_cpl_drop", {60'd0, cpl_valid}, 64'd0);
    checkOutput("single_hit_drop", {63'd0, cpl_hit}, 64'd0);
    checkOutput("single_idle", {63'd0, busy}, 64'd0);

    // Wrap: rr_ptr is 3, agents 1 and 3 valid -> 3 then 1
    applyStimulus(1, 64'h2000, 3'd2);
    applyStimulus(3, 64'h3000, 3'd3);
    waitAccept(g);
    checkOutput("wrap_first", {60'd0, g}, 64'b1000);
    @(negedge clk);
    req_valid[3] = 1'b0;
    waitAccept(g);
    checkOutput("wrap_second", {60'd0, g}, 64'b0010);
    @(negedge clk);
    req_valid[1] = 1'b0;
    tick();
    tick();
    tick();
    checkOutput("wrap_cpl_valid", {60'd0, cpl_valid}, 64'b0010);
    checkOutput("wrap_snoop_addr", snoop_addr, 64'h2000);
    checkOutput("wrap_snoop_type", {61'd0, snoop_type}, 64'd2);
    tick();

    // Illegal type 6 from agent 0: immediate error completion, no snoop
    applyStimulus(0, 64'h4000, 3'd6);
    #1;
    checkOutput("illegal_ready", {60'd0, req_ready}, 64'b0001);
    tick();
    req_valid = '0;
    checkOutput("illegal_cpl_valid", {60'd0, cpl_valid}, 64'b0001);
    checkOutput("illegal_cpl_err", {63'd0, cpl_err}, 64'd1);
    checkOutput("illegal_cpl_hit", {63'd0, cpl_hit}, 64'd0);
    checkOutput("illegal_no_snoop", {63'd0, snoop_req}, 64'd0);
    checkOutput("illegal_stat_issued", {32'd0, stat_issued}, 64'd8);
    checkOutput("illegal_addr_kept", snoop_addr, 64'h2000);
    tick();
    checkOutput("illegal_cpl_drop", {60'd0, cpl_valid}, 64'd0);
    checkOutput("illegal_err_drop", {63'd0, cpl_err}, 64'd0);
    checkOutput("illegal_no_snoop2", {63'd0, snoop_req}, 64'd0);
    checkOutput("illegal_idle", {63'd0, busy}, 64'd0);

    // Stability: only the T+2 response values may be captured
    applyStimulus(1, 64'h5000, 3'd4);
    #1;
    checkOutput("stab_ready", {60'd0, req_ready}, 64'b0010);
    tick();
    req_valid = '0;
    tick();
    snoop_hit   = 1'b0;
    snoop_dirty = 1'b1;
    snoop_resp  = 3'd5;
    checkOutput("stab_addr_t1", snoop_addr, 64'h5000);
    tick();
    snoop_hit   = 1'b1;
    snoop_dirty = 1'b0;
    snoop_resp  = 3'd2;
    checkOutput("stab_addr_t2", snoop_addr, 64'h5000);
    checkOutput("stab_type_t2", {61'd0, snoop_type}, 64'd4);
    tick();
    snoop_hit   = 1'b0;
    snoop_dirty = 1'b0;
    snoop_resp  = 3'd0;
    checkOutput("stab_cpl_valid", {60'd0, cpl_valid}, 64'b0010);
    checkOutput("stab_cpl_hit", {63'd0, cpl_hit}, 64'd1);
    checkOutput("stab_cpl_dirty", {63'd0, cpl_dirty}, 64'd0);
    checkOutput("stab_cpl_resp", {61'd0, cpl_resp}, 64'd2);
    checkOutput("stab_stat_issued", {32'd0, stat_issued}, 64'd9);
    checkOutput("stab_stat_hits", {32'd0, stat_hits}, 64'd2);
    checkOutput("stab_stat_dirty", {32'd0, stat_dirty}, 64'd1);
    tick();

    // Reset asserted during WAIT drops the snoop entirely
    applyStimulus(3, 64'h6000, 3'd0);
    tick();
    req_valid = '0;
    tick();
    rst_n       = 1'b0;
    snoop_hit   = 1'b1;
    snoop_dirty = 1'b1;
    tick();
    rst_n       = 1'b1;
    snoop_hit   = 1'b0;
    snoop_dirty = 1'b0;
    checkOutput("mid_rst_busy", {63'd0, busy}, 64'd0);
    checkOutput("mid_rst_cpl_valid", {60'd0, cpl_valid}, 64'd0);
    checkOutput("mid_rst_snoop_addr", snoop_addr, 64'd0);
    checkOutput("mid_rst_snoop_type", {61'd0, snoop_type}, 64'd0);
    checkOutput("mid_rst_stat_issued", {32'd0, stat_issued}, 64'd0);
    checkOutput("mid_rst_stat_hits", {32'd0, stat_hits}, 64'd0);
    tick();
    checkOutput("mid_rst_no_cpl", {60'd0, cpl_valid}, 64'd0);

    // Fresh request after reset; rr_ptr is back at 0
    applyStimulus(2, 64'h7000, 3'd3);
    #1;
    checkOutput("post_rst_ready", {60'd0, req_ready}, 64'b0100);
    tick();
    req_valid = '0;
    checkOutput("post_rst_snoop_req", {63'd0, snoop_req}, 64'd1);
    checkOutput("post_rst_snoop_addr", snoop_addr, 64'h7000);
    checkOutput("post_rst_stat_issued", {32'd0, stat_issued}, 64'd1);
    tick();
    tick();
    snoop_resp = 3'd1;
    tick();
    snoop_resp = 3'd0;
    checkOutput("post_rst_cpl_valid", {60'd0, cpl_valid}, 64'b0100);
    checkOutput("post_rst_cpl_resp", {61'd0, cpl_resp}, 64'd1);
    checkOutput("post_rst_stat_hits", {32'd0, stat_hits}, 64'd0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
